// File: rtl/fdiv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fdiv_arbiter
//  Description : Round-robin arbiter sharing one handshake floating-point
//                divider between NREQ requesters, one operation in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module fdiv_arbiter #(
    parameter int NREQ = 3,
    parameter int OW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_adata,
    input  logic [32*NREQ-1:0]   req_bdata,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 fdiv_en,
    output logic [31:0]          fdiv_adata,
    output logic [31:0]          fdiv_bdata,
    input  logic [31:0]          fdiv_result,
    input  logic                 fdiv_done,
    input  logic                 fdiv_busy,
    output logic                 busy,
    output logic [OW-1:0]        owner,
    output logic                 err
);

    localparam logic [1:0]    c_IDLE  = 2'd0;
    localparam logic [1:0]    c_ISSUE = 2'd1;
    localparam logic [1:0]    c_WAIT  = 2'd2;
    localparam logic [1:0]    c_RESP  = 2'd3;
    localparam logic [OW-1:0] c_LAST  = OW'(NREQ - 1);
    localparam logic [OW:0]   c_NREQ  = (OW + 1)'(NREQ);

    logic [1:0]    r_state_q,    w_state_d;
    logic [OW-1:0] r_ptr_q,      w_ptr_d;
    logic [OW-1:0] r_owner_q,    w_owner_d;
    logic          r_fdiv_en_q,  w_fdiv_en_d;
    logic [31:0]   r_adata_q,    w_adata_d;
    logic [31:0]   r_bdata_q,    w_bdata_d;
    logic [31:0]   r_rsp_data_q, w_rsp_data_d;
    logic          r_err_q,      w_err_d;

    logic [31:0]   w_adata_arr [NREQ];
    logic [31:0]   w_bdata_arr [NREQ];
    logic          w_grant_any;
    logic [OW-1:0] w_grant_idx;
    logic          w_grant_fire;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_adata_arr[gi] = req_adata[32*gi +: 32];
            assign w_bdata_arr[gi] = req_bdata[32*gi +: 32];
        end
    endgenerate

    // First set request at or above ptr, wrapping modulo NREQ.
    always_comb begin
        logic [OW:0] w_scan;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = {1'b0, r_ptr_q} + (OW + 1)'(k);
            if (w_scan >= c_NREQ) begin
                w_scan = w_scan - c_NREQ;
            end
            if (!w_grant_any && req_valid[w_scan[OW-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan[OW-1:0];
            end
        end
    end

    assign w_grant_fire = (r_state_q == c_IDLE) && w_grant_any;

    // FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q <= c_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_IDLE:  if (w_grant_any)          w_state_d = c_ISSUE;
            c_ISSUE:                           w_state_d = c_WAIT;
            c_WAIT:  if (fdiv_done)            w_state_d = c_RESP;
            c_RESP:  if (rsp_ready[r_owner_q]) w_state_d = c_IDLE;
            default:                           w_state_d = c_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = (r_state_q != c_IDLE);
        if (w_grant_fire) begin
            req_ready[w_grant_idx] = 1'b1;
        end
        if (r_state_q == c_RESP) begin
            rsp_valid[r_owner_q] = 1'b1;
        end
    end

    // Operands only move on a grant: the divider forwards them until it accepts.
    always_comb begin
        w_ptr_d      = r_ptr_q;
        w_owner_d    = r_owner_q;
        w_adata_d    = r_adata_q;
        w_bdata_d    = r_bdata_q;
        w_rsp_data_d = r_rsp_data_q;
        w_fdiv_en_d  = w_grant_fire;
        if (w_grant_fire) begin
            w_owner_d = w_grant_idx;
            w_ptr_d   = (w_grant_idx == c_LAST) ? '0 : w_grant_idx + 1'b1;
            w_adata_d = w_adata_arr[w_grant_idx];
            w_bdata_d = w_bdata_arr[w_grant_idx];
        end
        if ((r_state_q == c_WAIT) && fdiv_done) begin
            w_rsp_data_d = fdiv_result;
        end
        w_err_d = r_err_q
                | (fdiv_done && (r_state_q != c_WAIT))
                | (fdiv_busy && (r_state_q == c_IDLE));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr_q      <= '0;
            r_owner_q    <= '0;
            r_fdiv_en_q  <= 1'b0;
            r_adata_q    <= '0;
            r_bdata_q    <= '0;
            r_rsp_data_q <= '0;
            r_err_q      <= 1'b0;
        end else begin
            r_ptr_q      <= w_ptr_d;
            r_owner_q    <= w_owner_d;
            r_fdiv_en_q  <= w_fdiv_en_d;
            r_adata_q    <= w_adata_d;
            r_bdata_q    <= w_bdata_d;
            r_rsp_data_q <= w_rsp_data_d;
            r_err_q      <= w_err_d;
        end
    end

    assign fdiv_en    = r_fdiv_en_q;
    assign fdiv_adata = r_adata_q;
    assign fdiv_bdata = r_bdata_q;
    assign rsp_data   = r_rsp_data_q;
    assign owner      = r_owner_q;
    assign err        = r_err_q;

endmodule
`default_nettype wire

// File: doc/fdiv_arbiter.md
# fdiv_arbiter

Round-robin arbiter that shares one handshake-style floating-point divider unit between `NREQ` requesters. The divider unit takes a one-cycle `en` with stable operands, reports `busy`, and pulses `done` with `result`. Each requester gets a valid/ready request port and a valid/ready response port. The block sits between the core's FP issue logic (or multiple FP lanes) and the single divider instance, and keeps exactly one operation in flight.

## Interface
- `NREQ`, 3, number of requesters, 2..8
- `OW`, `$clog2(NREQ)`, width of owner index
- `clk`  in  1  clock, all logic on rising edge
- `rstn`  in  1  asynchronous active-low reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero
- `req_adata`  in  32*NREQ  dividend; requester i on bits [32i+31:32i]
- `req_bdata`  in  32*NREQ  divisor, same packing
- `rsp_valid`  out  NREQ  response valid, one-hot or zero
- `rsp_ready`  in  NREQ  per-requester response accept
- `rsp_data`  out  32  quotient, shared by all requesters
- `fdiv_en`  out  1  start pulse to the divider unit
- `fdiv_adata`  out  32  registered dividend to the divider
- `fdiv_bdata`  out  32  registered divisor to the divider
- `fdiv_result`  in  32  divider quotient, valid when `fdiv_done`=1
- `fdiv_done`  in  1  divider one-cycle completion pulse
- `fdiv_busy`  in  1  divider busy, used only for the error check
- `busy`  out  1  high whenever state≠IDLE
- `owner`  out  OW  index of the current or last granted requester
- `err`  out  1  sticky protocol-error flag

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is set, grant g = the first set bit searching from `ptr` upward, wrapping modulo NREQ.
  - `req_ready[g]`=1 combinationally in the same cycle. The handshake completes in that cycle.
  - Register the slice g of `req_adata` and `req_bdata` into `fdiv_adata` and `fdiv_bdata`.
  - Set `owner`<=g and `ptr`<=(g+1) mod NREQ.
  - Go to ISSUE.
  - `req_ready` is 0 in all other states.
- **ISSUE**
  - `fdiv_en`=1, registered, for exactly this one cycle.
  - Go to WAIT.
- **WAIT**
  - On `fdiv_done`=1, capture `fdiv_result` into `rsp_data` and go to RESP.
  - No timeout.
- **RESP**
  - `rsp_valid[owner]`=1 and `rsp_data` is held.
  - When `rsp_ready[owner]`=1, go to IDLE next cycle.
  - `rsp_ready` bits of non-owners are ignored.
- **Operand stability**
  - `fdiv_adata` and `fdiv_bdata` change only on an IDLE grant.
  - They are held from ISSUE through RESP, because the divider forwards them combinationally until its input handshake completes.
- **Error flag** (`err`), sticky until reset, is set by either of:
  - `fdiv_done`=1 in any state other than WAIT;
  - `fdiv_busy`=1 while in IDLE.
  
  The FSM takes no action on an error.
- **Fairness:** a requester holding `req_valid` is granted within NREQ operations.

## Timing
- **Reset values:** state=IDLE, `ptr`=0, `owner`=0, `fdiv_en`=0, `fdiv_adata`=0, `fdiv_bdata`=0, `rsp_data`=0, `rsp_valid`=0, `req_ready`=0, `busy`=0, `err`=0.
- **Reset mid-operation:**
  - Everything returns to reset values immediately.
  - An in-flight response is dropped. The divider is reset by the same `rstn`.
- **Sequence for an accept at cycle 0:**
  - cycle 0: `req_ready`=1.
  - cycle 1: `fdiv_en`=1.
  - cycle 2 onward: WAIT.
  - `fdiv_done` seen at cycle d: RESP and `rsp_valid`=1 at cycle d+1.
  - With `rsp_ready` already high, IDLE at d+2; the next accept is possible at d+2.
- **Spacing:** at least 2 cycles between a `fdiv_done` and the next `fdiv_en`, so the divider is back in its wait state.
- **Simultaneous events:**
  - Requests arriving during ISSUE, WAIT or RESP wait in IDLE arbitration.
  - A requester may hold `req_valid` and data unchanged until its `req_ready` pulse.

## Test plan
- **Single op:** NREQ=3, divider model with 5-cycle latency. req0 sends 0x3F800000 / 0x40000000.
  - `fdiv_en` is asserted at cycle 1.
  - `rsp_valid`=3'b001 with `rsp_data`=0x3F000000, 7 cycles after accept.
- **Round-robin:** all three `req_valid` held high from reset.
  - Grant order is 0,1,2,0,1,2.
  - `owner` matches each grant, and `req_ready` is never multi-hot.
- **Response backpressure:** req1 sends 0x40C00000 / 0x40400000 with `rsp_ready[1]`=0 for 10 cycles.
  - `rsp_valid[1]` and `rsp_data`=0x40000000 are held stable throughout.
  - A pending req2 is not accepted until the cycle after `rsp_ready[1]`=1.
- **Operand hold:** change `req_adata` slice 0 right after its accept.
  - `fdiv_adata` stays at the accepted value until the next grant.
- **Error:** inject `fdiv_done` in IDLE.
  - `err`=1 and stays 1.
  - The FSM stays in IDLE and the next op still completes normally.
- **Reset mid-op:** drop `rstn` during WAIT.
  - All outputs reach reset values asynchronously.
  - A post-reset op from req2 is granted first, with `ptr`=0 search order.
